// File: rtl/tai_bus_ctrl.sv
// TAI bus direction controller: drives/listens on a shared tri-state TAI bus with
// guarded turnarounds, synchronised receive path, stability filter and glitch counter.
module tai_bus_ctrl #(
  parameter int unsigned W          = 10,
  parameter int unsigned TURN_CYC   = 4,
  parameter int unsigned STABLE_CYC = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode_master,
  input  logic [W-1:0] tx_tai,
  input  logic         tx_load,
  input  logic [W-1:0] tai_i,
  output logic [W-1:0] tai_o,
  output logic         tai_t,
  output logic [W-1:0] rx_tai,
  output logic         rx_valid,
  output logic [7:0]   glitch_cnt,
  input  logic         glitch_clr,
  output logic [1:0]   dir_state
);

  typedef enum logic [1:0] {
    LISTEN   = 2'd0,
    TURN_OUT = 2'd1,
    DRIVE    = 2'd2,
    TURN_IN  = 2'd3
  } state_e;

  localparam logic [7:0] TURN_LAST   = 8'(TURN_CYC - 1);
  localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYC);
  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYC - 1);

  state_e         state_q, state_d;
  logic [7:0]     turn_q, turn_d;
  logic           tai_t_q;
  logic [W-1:0]   tai_o_q;
  logic [W-1:0]   s1_q, s2_q;
  logic [7:0]     cnt_q, cnt_d;
  logic [7:0]     glitch_q, glitch_d;
  logic [W-1:0]   rx_tai_q, rx_tai_d;
  logic           rx_valid_q, rx_valid_d;

  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    unique case (state_q)
      LISTEN: begin
        turn_d = '0;
        if (mode_master) state_d = TURN_OUT;
      end
      TURN_OUT: begin
        if (!mode_master) begin
          state_d = LISTEN;
          turn_d  = '0;
        end else if (turn_q == TURN_LAST) begin
          state_d = DRIVE;
          turn_d  = '0;
        end else begin
          turn_d = turn_q + 8'd1;
        end
      end
      DRIVE: begin
        turn_d = '0;
        if (!mode_master) state_d = TURN_IN;
      end
      TURN_IN: begin
        // Releasing the bus always runs to completion, whatever mode_master does.
        if (turn_q == TURN_LAST) begin
          state_d = LISTEN;
          turn_d  = '0;
        end else begin
          turn_d = turn_q + 8'd1;
        end
      end
      default: begin
        state_d = LISTEN;
        turn_d  = '0;
      end
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    glitch_d   = glitch_q;
    rx_tai_d   = rx_tai_q;
    rx_valid_d = 1'b0;
    if (state_q == LISTEN) begin
      if (s1_q != s2_q) begin
        cnt_d = '0;
        // A change arriving after a fully stable period is a legitimate update, not a glitch.
        if (cnt_q < STABLE_MAX && glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;
      end else begin
        if (cnt_q == STABLE_LAST) begin
          rx_tai_d   = s2_q;
          rx_valid_d = 1'b1;
        end
        if (cnt_q < STABLE_MAX) cnt_d = cnt_q + 8'd1;
      end
    end else begin
      cnt_d = '0;
    end
    if (glitch_clr) glitch_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LISTEN;
      turn_q     <= '0;
      tai_t_q    <= 1'b1;
      tai_o_q    <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      cnt_q      <= '0;
      glitch_q   <= '0;
      rx_tai_q   <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_q     <= turn_d;
      // Enable derived from the next state so it switches on the same edge as dir_state.
      tai_t_q    <= (state_d != DRIVE);
      if (tx_load) tai_o_q <= tx_tai;
      s1_q       <= tai_i;
      s2_q       <= s1_q;
      cnt_q      <= cnt_d;
      glitch_q   <= glitch_d;
      rx_tai_q   <= rx_tai_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tai_o      = tai_o_q;
  assign tai_t      = tai_t_q;
  assign rx_tai     = rx_tai_q;
  assign rx_valid   = rx_valid_q;
  assign glitch_cnt = glitch_q;
  assign dir_state  = state_q;

endmodule

// File: tb/tb_tai_bus_ctrl.sv
// Bench for tai_bus_ctrl: directed scenarios plus random traffic, checked against a
// behavioural model; received-value pulses are matched through a scoreboard queue.
module tb_tai_bus_ctrl;

  localparam int W  = 10;
  localparam int TC = 4;
  localparam int SC = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode_master;
  logic [W-1:0] tx_tai;
  logic         tx_load;
  logic [W-1:0] tai_i;
  logic [W-1:0] tai_o;
  logic         tai_t;
  logic [W-1:0] rx_tai;
  logic         rx_valid;
  logic [7:0]   glitch_cnt;
  logic         glitch_clr;
  logic [1:0]   dir_state;

  always #5 clk = ~clk;

  tai_bus_ctrl #(.W(W), .TURN_CYC(TC), .STABLE_CYC(SC)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_master(mode_master),
    .tx_tai     (tx_tai),
    .tx_load    (tx_load),
    .tai_i      (tai_i),
    .tai_o      (tai_o),
    .tai_t      (tai_t),
    .rx_tai     (rx_tai),
    .rx_valid   (rx_valid),
    .glitch_cnt (glitch_cnt),
    .glitch_clr (glitch_clr),
    .dir_state  (dir_state)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: direction phase with remaining-cycle budget, the two most
  // recent bus samples seen by the receiver, and length of the current quiet run.
  int           m_state = 0;
  int           m_left  = 0;
  logic [W-1:0] m_tai_o = '0;
  logic [W-1:0] m_rx    = '0;
  int           m_glitch = 0;
  int           m_run   = 0;
  logic [W-1:0] h_new   = '0;
  logic [W-1:0] h_old   = '0;
  logic [W-1:0] exp_q[$];
  bit           started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit listen;
    bit quiet;
    if (rst) begin
      m_state  = 0;
      m_left   = 0;
      m_tai_o  = '0;
      m_rx     = '0;
      m_glitch = 0;
      m_run    = 0;
      h_new    = '0;
      h_old    = '0;
    end else begin
      listen = (m_state == 0);
      quiet  = listen && (h_new == h_old);
      if (glitch_clr) m_glitch = 0;
      else if (listen && h_new != h_old && m_run < SC && m_glitch < 255) m_glitch++;
      if (quiet && m_run == SC - 1) begin
        exp_q.push_back(h_old);
        m_rx = h_old;
      end
      m_run = quiet ? ((m_run < SC) ? m_run + 1 : SC) : 0;
      h_old = h_new;
      h_new = tai_i;
      if (tx_load) m_tai_o = tx_tai;
      case (m_state)
        0: if (mode_master) begin m_state = 1; m_left = TC; end
        1: begin
          if (!mode_master) m_state = 0;
          else if (m_left == 1) m_state = 2;
          else m_left--;
        end
        2: if (!mode_master) begin m_state = 3; m_left = TC; end
        default: begin
          if (m_left == 1) m_state = 0;
          else m_left--;
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    started = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("dir_state",  32'(dir_state),  32'(m_state));
      check("tai_t",      32'(tai_t),      32'(m_state != 2));
      check("tai_o",      32'(tai_o),      32'(m_tai_o));
      check("glitch_cnt", 32'(glitch_cnt), 32'(m_glitch));
      check("rx_tai",     32'(rx_tai),     32'(m_rx));
      if (rx_valid) begin
        if (exp_q.size() == 0) check("rx_valid_unexpected", 32'(rx_valid), 32'd0);
        else check("rx_pulse_value", 32'(rx_tai), 32'(exp_q.pop_front()));
      end else if (exp_q.size() != 0) begin
        check("rx_valid_missing", 32'(rx_valid), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] rnd;
    rst = 1'b1; mode_master = 1'b0; tx_tai = '0; tx_load = 1'b0;
    glitch_clr = 1'b0; tai_i = 10'h0F3;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();

    tai_i = 10'h000; repeat (15) tick();
    tai_i = 10'h155; repeat (15) tick();

    for (int i = 0; i < 5; i++) begin
      tai_i = (tai_i == 10'h155) ? 10'h0AA : 10'h155;
      repeat (3) tick();
    end
    repeat (15) tick();

    for (int i = 0; i < 300; i++) begin
      tai_i = (tai_i == 10'h155) ? 10'h0AA : 10'h155;
      repeat (3) tick();
    end
    tai_i = (tai_i == 10'h155) ? 10'h0AA : 10'h155;
    tick();
    glitch_clr = 1'b1; tick(); glitch_clr = 1'b0;
    repeat (15) tick();

    mode_master = 1'b1; repeat (2) tick();
    mode_master = 1'b0; repeat (12) tick();

    tx_tai = 10'h2A5; tx_load = 1'b1; tick(); tx_load = 1'b0;
    mode_master = 1'b1; repeat (6) tick();
    tx_tai = 10'h15A; tx_load = 1'b1; tick(); tx_load = 1'b0;
    repeat (3) tick();
    mode_master = 1'b0; repeat (12) tick();

    mode_master = 1'b1; repeat (8) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    mode_master = 1'b0; repeat (12) tick();

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) mode_master = ~mode_master;
      if ($urandom_range(0, 9) == 0) begin rnd = $urandom; tai_i = rnd[W-1:0]; end
      rnd = $urandom; tx_tai = rnd[W-1:0];
      tx_load    = ($urandom_range(0, 7) == 0);
      glitch_clr = ($urandom_range(0, 63) == 0);
      rst        = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; tx_load = 1'b0; glitch_clr = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tai_bus_ctrl.md
TAI_BUS_CTRL -- requirements
Module: tai_bus_ctrl

Interface
REQ-001 Parameter: W, 10, TAI bus width in bits.
REQ-002 Parameter: TURN_CYC, 4, bus turnaround length in clk cycles; legal range 1-255.
REQ-003 Parameter: STABLE_CYC, 8, consecutive equal samples required to accept a received value; legal range 2-255.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port: clk  in  1  sole clock; all logic on its rising edge.
REQ-006 Port: rst  in  1  synchronous, active-high reset.
REQ-007 Port: mode_master  in  1  1 = this board drives the TAI bus, 0 = this board listens.
REQ-008 Port: tx_tai  in  W  TAI value to drive.
REQ-009 Port: tx_load  in  1  single-cycle strobe; captures tx_tai.
REQ-010 Port: tai_i  in  W  IOBUF O bank; asynchronous to clk.
REQ-011 Port: tai_o  out  W  IOBUF I bank; registered.
REQ-012 Port: tai_t  out  1  IOBUF T, all bits; 1 = high-Z/input, 0 = drive; registered.
REQ-013 Port: rx_tai  out  W  last accepted received value.
REQ-014 Port: rx_valid  out  1  one-cycle pulse when rx_tai updates.
REQ-015 Port: glitch_cnt  out  8  saturating count of unstable bus changes.
REQ-016 Port: glitch_clr  in  1  single-cycle strobe; clears glitch_cnt.
REQ-017 Port: dir_state  out  2  FSM state: 0 LISTEN, 1 TURN_OUT, 2 DRIVE, 3 TURN_IN.

Function
REQ-018 FSM transitions: LISTEN and mode_master=1 -> TURN_OUT.
REQ-019 TURN_OUT SHALL last exactly TURN_CYC cycles, then -> DRIVE; if mode_master=0 in any TURN_OUT cycle, go -> LISTEN at the next edge.
REQ-020 DRIVE and mode_master=0 -> TURN_IN.
REQ-021 TURN_IN SHALL always complete exactly TURN_CYC cycles, then -> LISTEN, regardless of mode_master; a held mode_master=1 then takes LISTEN -> TURN_OUT on the following edge.
REQ-022 tai_t SHALL be 0 exactly in the cycles where dir_state=2; tai_t and dir_state update on the same edge (no combinational path from mode_master to tai_t).
REQ-023 tai_o SHALL load tx_tai on the edge where tx_load=1, in any state, and hold otherwise; the bus reflects it when tai_t=0.
REQ-024 tai_i SHALL pass through a 2-flop synchronizer, s1 then s2.
REQ-025 Stability counter cnt: s1!=s2 -> cnt<=0; else cnt<=cnt+1, saturating at STABLE_CYC. cnt is held at 0 whenever the state is not LISTEN.
REQ-026 In LISTEN, on an edge where s1==s2 and cnt==STABLE_CYC-1: rx_tai<=s2 and rx_valid<=1 for one cycle; at most one pulse per stable period.
REQ-027 Latency: with tai_i settled to a new value before edge E0 in LISTEN, rx_tai and rx_valid SHALL update at edge E0+STABLE_CYC+1.
REQ-028 Glitch rule: in LISTEN, s1!=s2 while cnt<STABLE_CYC SHALL increment glitch_cnt, saturating at 255.
REQ-029 glitch_clr has priority over a simultaneous increment; result 0.
REQ-030 RX acceptance and glitch counting SHALL be inactive in TURN_OUT, DRIVE and TURN_IN.
REQ-031 On re-entry to LISTEN, the current bus value SHALL be reported once it is stable for STABLE_CYC.

Reset
REQ-032 While rst=1, at each edge: state=LISTEN, tai_t=1, tai_o=0, rx_tai=0, rx_valid=0, glitch_cnt=0, cnt=0, s1=s2=0, turnaround counter=0.
REQ-033 rst asserted during DRIVE SHALL release the bus (tai_t=1) at the same edge; there is no turnaround on reset.
REQ-034 After reset with a constant tai_i=X, rx_valid SHALL pulse once with rx_tai=X.

Verification
REQ-035 Parameters 4/8; mode_master 0->1 held -> dir_state 1 for 4 cycles, then 2; tai_t falls with dir_state=2; tx_load 0x2A5 -> tai_o=0x2A5 next cycle.
REQ-036 In DRIVE, mode_master->0 -> dir_state 3 for exactly 4 cycles, then 0; tai_t=1 from the first TURN_IN cycle.
REQ-037 In LISTEN, tai_i 0x000->0x155 before E0 -> rx_valid single pulse at E0+9, rx_tai=0x155, glitch_cnt unchanged.
REQ-038 In LISTEN, tai_i toggles 0x155/0x0AA every 3 cycles for 5 toggles -> no rx_valid, glitch_cnt +4 (first change from a stable value is not counted); 300 toggles -> glitch_cnt=255; glitch_clr together with a toggle -> 0.
REQ-039 mode_master pulses high 2 cycles in LISTEN -> TURN_OUT, abort to LISTEN, tai_t never 0; rst pulse mid-DRIVE -> tai_t=1, dir_state=0 next edge, and all outputs at their reset values.
